// File: rtl/notch_cfg_ctrl.sv
// rtl/notch_cfg_ctrl.sv - APB configuration and commit sequencer for two cascaded IIR notch stages
//
// Purpose: holds shadow coefficient and bypass registers written over APB,
// copies them to the active outputs on the first sample_strobe after a
// COMMIT, then holds the filters in reset for FLUSH_CYCLES cycles.
//
// Ports:
//   CLK, rst             clock, synchronous active-high reset
//   PSEL..PSLVERR        zero-wait-state APB slave (PREADY tied high)
//   sample_strobe        one-cycle pulse per input sample
//   coeff_s1, coeff_s2   active coefficients {b0,b1,b2,a1,a2}, b0 in the MSBs
//   en_out               EN to both stages
//   bypass_s1, bypass_s2 per-stage bypass (updated only on commit)
//   filt_rst_n           active-low reset to both stages
//   busy                 commit pending or flushing

module notch_cfg_ctrl #(
  parameter int                 WIDTH        = 16,
  parameter int                 FLUSH_CYCLES = 4,
  parameter logic [5*WIDTH-1:0] DEF_COEFF1   = {16'h4000, 16'h678e, 16'h4000, 16'h6473, 16'h3c38},
  parameter logic [5*WIDTH-1:0] DEF_COEFF2   = {16'h4000, 16'hc000, 16'h4000, 16'hc1ec, 16'h3c38}
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [7:0]           PADDR,
  input  logic [15:0]          PWDATA,
  output logic [15:0]          PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  input  logic                 sample_strobe,
  output logic [5*WIDTH-1:0]   coeff_s1,
  output logic [5*WIDTH-1:0]   coeff_s2,
  output logic                 en_out,
  output logic                 bypass_s1,
  output logic                 bypass_s2,
  output logic                 filt_rst_n,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_STB = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  localparam logic [7:0] A_LAST_COEFF = 8'h24;
  localparam logic [7:0] A_CTRL       = 8'h28;
  localparam logic [7:0] A_STATUS     = 8'h2C;
  localparam logic [7:0] A_ERRCLR     = 8'h30;

  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

  logic [1:0]           state;
  logic [7:0]           flush_cnt;
  logic [7:0]           commit_cnt;
  logic                 err;
  logic [5*WIDTH-1:0]   sh1;
  logic [5*WIDTH-1:0]   sh2;
  logic                 byp1_sh;
  logic                 byp2_sh;

  logic                 access;
  logic                 mapped;
  logic                 is_coeff;
  logic                 is_ctrl;
  logic [3:0]           coeff_idx;
  logic                 busy_viol;
  logic                 wr_ok;
  logic [WIDTH-1:0]     rd_coeff;

  assign access    = PSEL & PENABLE;
  assign mapped    = (PADDR[1:0] == 2'b00) && (PADDR <= A_ERRCLR);
  assign is_coeff  = mapped && (PADDR <= A_LAST_COEFF);
  assign is_ctrl   = (PADDR == A_CTRL);
  // word index 0..4 selects stage-1 b0..a2, 5..9 selects stage-2 b0..a2
  assign coeff_idx = PADDR[5:2];

  assign busy      = (state != ST_IDLE);
  // a commit in flight owns the shadow registers: coefficient writes and a
  // second COMMIT are refused, plain EN/BYP updates still go through
  assign busy_viol = access & PWRITE & busy & (is_coeff | (is_ctrl & PWDATA[3]));
  assign wr_ok     = access & PWRITE & mapped & ~busy_viol;

  assign PREADY     = 1'b1;
  assign PSLVERR    = access & (~mapped | busy_viol);
  assign filt_rst_n = ~(rst | (state == ST_FLUSH));

  always_comb begin
    rd_coeff = '0;
    for (int i = 0; i < 5; i++) begin
      if (coeff_idx == 4'(i))     rd_coeff = sh1[(4-i)*WIDTH +: WIDTH];
      if (coeff_idx == 4'(i + 5)) rd_coeff = sh2[(4-i)*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    PRDATA = '0;
    if (access && !PWRITE && mapped) begin
      if (is_coeff)
        PRDATA = 16'(rd_coeff);
      else if (is_ctrl)
        PRDATA = {13'd0, byp2_sh, byp1_sh, en_out};
      else if (PADDR == A_STATUS)
        PRDATA = {commit_cnt, 6'd0, err, busy};
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state      <= ST_IDLE;
      flush_cnt  <= '0;
      commit_cnt <= '0;
      err        <= 1'b0;
      sh1        <= DEF_COEFF1;
      sh2        <= DEF_COEFF2;
      byp1_sh    <= 1'b0;
      byp2_sh    <= 1'b0;
      coeff_s1   <= DEF_COEFF1;
      coeff_s2   <= DEF_COEFF2;
      en_out     <= 1'b0;
      bypass_s1  <= 1'b0;
      bypass_s2  <= 1'b0;
    end else begin
      if (wr_ok) begin
        for (int i = 0; i < 5; i++) begin
          if (is_coeff && coeff_idx == 4'(i))     sh1[(4-i)*WIDTH +: WIDTH] <= PWDATA[WIDTH-1:0];
          if (is_coeff && coeff_idx == 4'(i + 5)) sh2[(4-i)*WIDTH +: WIDTH] <= PWDATA[WIDTH-1:0];
        end
        if (is_ctrl) begin
          en_out  <= PWDATA[0];
          byp1_sh <= PWDATA[1];
          byp2_sh <= PWDATA[2];
        end
        if (PADDR == A_ERRCLR)
          err <= 1'b0;
      end
      if (busy_viol)
        err <= 1'b1;

      case (state)
        ST_IDLE: begin
          // a strobe coinciding with the COMMIT write is not used; the
          // first usable strobe is sampled in WAIT_STB
          if (wr_ok && is_ctrl && PWDATA[3])
            state <= ST_WAIT_STB;
        end
        ST_WAIT_STB: begin
          if (sample_strobe) begin
            coeff_s1  <= sh1;
            coeff_s2  <= sh2;
            bypass_s1 <= byp1_sh;
            bypass_s2 <= byp2_sh;
            flush_cnt <= '0;
            state     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state      <= ST_IDLE;
            commit_cnt <= commit_cnt + 8'd1;
          end else begin
            flush_cnt <= flush_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_notch_cfg_ctrl.sv
// tb/tb_notch_cfg_ctrl.sv - self-checking bench for notch_cfg_ctrl

module tb_notch_cfg_ctrl;

  localparam int FC = 4;
  localparam logic [79:0] DEF1 = {16'h4000, 16'h678e, 16'h4000, 16'h6473, 16'h3c38};
  localparam logic [79:0] DEF2 = {16'h4000, 16'hc000, 16'h4000, 16'hc1ec, 16'h3c38};

  logic        CLK = 1'b0;
  logic        rst;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [15:0] PWDATA;
  logic [15:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        sample_strobe;
  logic [79:0] coeff_s1, coeff_s2;
  logic        en_out, bypass_s1, bypass_s2, filt_rst_n, busy;

  notch_cfg_ctrl #(.WIDTH(16), .FLUSH_CYCLES(FC)) dut (
    .CLK(CLK), .rst(rst),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .sample_strobe(sample_strobe),
    .coeff_s1(coeff_s1), .coeff_s2(coeff_s2),
    .en_out(en_out), .bypass_s1(bypass_s1), .bypass_s2(bypass_s2),
    .filt_rst_n(filt_rst_n), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    logic [7:0]  addr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] fld(input logic [79:0] c, input int i);
    return c[(4-i)*16 +: 16];
  endfunction

  // APB scoreboard: expectations are queued when the access phase is driven
  // and consumed when the access phase is observed on the bus.
  always @(negedge CLK) begin
    exp_t e;
    if (PSEL && PENABLE) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL apb_unexpected: access at %0h with no queued expectation", PADDR);
      end else begin
        e = sb.pop_front();
        check($sformatf("apb_rdata_%02h", e.addr), 80'(PRDATA), 80'(e.rdata));
        check($sformatf("apb_pslverr_%02h", e.addr), 80'(PSLVERR), 80'(e.err));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic apb(input logic wr, input logic [7:0] addr, input logic [15:0] wdata,
                     input logic [15:0] exp_rd, input logic exp_err, input logic strb);
    exp_t e;
    @(posedge CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge CLK); #1;
    PENABLE = 1'b1; sample_strobe = strb;
    e.rdata = exp_rd; e.err = exp_err; e.addr = addr;
    sb.push_back(e);
    @(posedge CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; sample_strobe = 1'b0;
  endtask

  task automatic strobe_pulse();
    @(posedge CLK); #1;
    sample_strobe = 1'b1;
    @(posedge CLK); #1;
    sample_strobe = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      step(1);
      k++;
    end
    check("wait_idle_busy", 80'(busy), 80'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1'b0, 8'h04, 16'h0000, 16'h678e, 1'b0};
    tbl[1]  = '{1'b0, 8'h18, 16'h0000, 16'hc000, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 16'h0000, 16'h4000, 1'b0};
    tbl[3]  = '{1'b0, 8'h10, 16'h0000, 16'h3c38, 1'b0};
    tbl[4]  = '{1'b0, 8'h20, 16'h0000, 16'hc1ec, 1'b0};
    tbl[5]  = '{1'b0, 8'h24, 16'h0000, 16'h3c38, 1'b0};
    tbl[6]  = '{1'b0, 8'h28, 16'h0000, 16'h0000, 1'b0};
    tbl[7]  = '{1'b0, 8'h2c, 16'h0000, 16'h0000, 1'b0};
    tbl[8]  = '{1'b0, 8'h34, 16'h0000, 16'h0000, 1'b1};
    tbl[9]  = '{1'b0, 8'h02, 16'h0000, 16'h0000, 1'b1};
    tbl[10] = '{1'b1, 8'h02, 16'hffff, 16'h0000, 1'b1};
    tbl[11] = '{1'b1, 8'h0c, 16'h5555, 16'h0000, 1'b0};
    tbl[12] = '{1'b0, 8'h0c, 16'h0000, 16'h5555, 1'b0};
    tbl[13] = '{1'b1, 8'h0c, 16'h6473, 16'h0000, 1'b0};
    tbl[14] = '{1'b0, 8'hfc, 16'h0000, 16'h0000, 1'b1};
    tbl[15] = '{1'b0, 8'h0d, 16'h0000, 16'h0000, 1'b1};

    rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; sample_strobe = 1'b0;
    step(3);

    check("rst_filt_rst_n", 80'(filt_rst_n), 80'(0));
    check("rst_busy", 80'(busy), 80'(0));
    check("rst_en_out", 80'(en_out), 80'(0));
    check("rst_bypass", 80'({bypass_s1, bypass_s2}), 80'(0));
    check("rst_coeff_s1", coeff_s1, DEF1);
    check("rst_coeff_s2", coeff_s2, DEF2);
    check("rst_prdata", 80'(PRDATA), 80'(0));
    check("rst_pslverr", 80'(PSLVERR), 80'(0));

    rst = 1'b0;
    #1;
    check("post_rst_filt_rst_n", 80'(filt_rst_n), 80'(1));
    check("pready", 80'(PREADY), 80'(1));

    // register map, decode errors and shadow-only writes
    for (int i = 0; i < 16; i++)
      apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err, 1'b0);
    check("shadow_write_active_s1", coeff_s1, DEF1);
    check("idle_prdata", 80'(PRDATA), 80'(0));

    // basic commit: strobe 10 cycles after the COMMIT write
    apb(1'b1, 8'h04, 16'h1234, 16'h0000, 1'b0, 1'b0);
    apb(1'b1, 8'h28, 16'h0009, 16'h0000, 1'b0, 1'b0);
    check("commit_busy", 80'(busy), 80'(1));
    check("commit_en_out", 80'(en_out), 80'(1));
    for (int i = 0; i < 9; i++) begin
      step(1);
      check("wait_b1_old", 80'(fld(coeff_s1, 1)), 80'(16'h678e));
    end
    sample_strobe = 1'b1;
    check("strobe_cycle_b1_old", 80'(fld(coeff_s1, 1)), 80'(16'h678e));
    check("strobe_cycle_filt_rst_n", 80'(filt_rst_n), 80'(1));
    step(1);
    sample_strobe = 1'b0;
    check("s1_b1_new", 80'(fld(coeff_s1, 1)), 80'(16'h1234));
    check("s1_filt_rst_n", 80'(filt_rst_n), 80'(0));
    check("s1_busy", 80'(busy), 80'(1));
    for (int k = 2; k <= FC; k++) begin
      step(1);
      check("flush_filt_rst_n", 80'(filt_rst_n), 80'(0));
      check("flush_busy", 80'(busy), 80'(1));
    end
    step(1);
    check("done_busy", 80'(busy), 80'(0));
    check("done_filt_rst_n", 80'(filt_rst_n), 80'(1));
    check("done_coeff_s1", coeff_s1, {16'h4000, 16'h1234, 16'h4000, 16'h6473, 16'h3c38});
    check("done_coeff_s2", coeff_s2, DEF2);
    apb(1'b0, 8'h2c, 16'h0000, 16'h0100, 1'b0, 1'b0);

    // writes refused while busy, err sticky and clear
    apb(1'b1, 8'h28, 16'h0009, 16'h0000, 1'b0, 1'b0);
    apb(1'b1, 8'h00, 16'h0000, 16'h0000, 1'b1, 1'b0);
    apb(1'b0, 8'h00, 16'h0000, 16'h4000, 1'b0, 1'b0);
    apb(1'b0, 8'h2c, 16'h0000, 16'h0103, 1'b0, 1'b0);
    apb(1'b1, 8'h30, 16'h0000, 16'h0000, 1'b0, 1'b0);
    apb(1'b0, 8'h2c, 16'h0000, 16'h0101, 1'b0, 1'b0);
    apb(1'b1, 8'h28, 16'h000f, 16'h0000, 1'b1, 1'b0);
    apb(1'b1, 8'h28, 16'h0003, 16'h0000, 1'b0, 1'b0);
    apb(1'b0, 8'h28, 16'h0000, 16'h0003, 1'b0, 1'b0);
    check("byp_shadow_only", 80'(bypass_s1), 80'(0));
    apb(1'b1, 8'h30, 16'h0000, 16'h0000, 1'b0, 1'b0);
    strobe_pulse();
    check("byp1_committed", 80'(bypass_s1), 80'(1));
    check("byp2_committed", 80'(bypass_s2), 80'(0));
    wait_idle(FC + 4);
    check("busy_commit_b0", 80'(fld(coeff_s1, 0)), 80'(16'h4000));
    apb(1'b0, 8'h2c, 16'h0000, 16'h0200, 1'b0, 1'b0);

    // COMMIT write and strobe in the same cycle
    apb(1'b1, 8'h08, 16'h2222, 16'h0000, 1'b0, 1'b0);
    apb(1'b1, 8'h28, 16'h0009, 16'h0000, 1'b0, 1'b1);
    check("same_cycle_busy", 80'(busy), 80'(1));
    check("same_cycle_b2_old", 80'(fld(coeff_s1, 2)), 80'(16'h4000));
    check("same_cycle_filt_rst_n", 80'(filt_rst_n), 80'(1));
    step(3);
    check("same_cycle_b2_still_old", 80'(fld(coeff_s1, 2)), 80'(16'h4000));
    strobe_pulse();
    check("next_strobe_b2_new", 80'(fld(coeff_s1, 2)), 80'(16'h2222));
    check("next_strobe_filt_rst_n", 80'(filt_rst_n), 80'(0));
    check("next_strobe_byp1", 80'(bypass_s1), 80'(0));
    wait_idle(FC + 4);
    apb(1'b0, 8'h2c, 16'h0000, 16'h0300, 1'b0, 1'b0);

    // reset in the second FLUSH cycle
    apb(1'b1, 8'h14, 16'h1111, 16'h0000, 1'b0, 1'b0);
    apb(1'b1, 8'h28, 16'h0009, 16'h0000, 1'b0, 1'b0);
    strobe_pulse();
    check("pre_rst_s2_b0", 80'(fld(coeff_s2, 0)), 80'(16'h1111));
    step(1);
    rst = 1'b1;
    #1;
    check("mid_rst_filt_rst_n", 80'(filt_rst_n), 80'(0));
    step(1);
    rst = 1'b0;
    #1;
    check("after_rst_coeff_s1", coeff_s1, DEF1);
    check("after_rst_coeff_s2", coeff_s2, DEF2);
    check("after_rst_busy", 80'(busy), 80'(0));
    check("after_rst_filt_rst_n", 80'(filt_rst_n), 80'(1));
    check("after_rst_en_out", 80'(en_out), 80'(0));
    step(2);
    check("after_rst_filt_rst_n_stays", 80'(filt_rst_n), 80'(1));
    apb(1'b0, 8'h2c, 16'h0000, 16'h0000, 1'b0, 1'b0);
    apb(1'b0, 8'h14, 16'h0000, 16'h4000, 1'b0, 1'b0);
    apb(1'b0, 8'h04, 16'h0000, 16'h678e, 1'b0, 1'b0);

    // commit counter wraps after 256 commits
    for (int n = 1; n <= 256; n++) begin
      apb(1'b1, 8'h28, 16'h0008, 16'h0000, 1'b0, 1'b0);
      strobe_pulse();
      wait_idle(FC + 4);
      if (n == 255)
        apb(1'b0, 8'h2c, 16'h0000, 16'hff00, 1'b0, 1'b0);
    end
    apb(1'b0, 8'h2c, 16'h0000, 16'h0000, 1'b0, 1'b0);

    step(2);
    check("scoreboard_drained", 80'(sb.size()), 80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
